// File: rtl/serdes_tx_scheduler.sv
// rtl/serdes_tx_scheduler.sv - link-layer symbol scheduler feeding serdes_tx
// Payload FIFO plus framing FSM that advances one 9-bit {K,byte} symbol per load strobe.
module serdes_tx_scheduler #(
  parameter int FIFO_DEPTH  = 16,
  parameter int ALIGN_COUNT = 8,
  parameter int MIN_IDLE    = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          s_valid,
  input  logic [7:0]                    s_data,
  input  logic                          s_last,
  output logic                          s_ready,
  input  logic                          sym_req,
  output logic [8:0]                    sym_out,
  output logic                          aligning,
  output logic                          busy,
  output logic                          underrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int LW  = AW + 1;
  localparam int ACW = $clog2(ALIGN_COUNT + 1);
  localparam int GW  = $clog2(MIN_IDLE + 1);

  localparam logic [LW-1:0]  FULL_LEVEL = LW'(FIFO_DEPTH);
  localparam logic [ACW-1:0] ALIGN_LAST = ACW'(ALIGN_COUNT - 1);
  localparam logic [GW-1:0]  GAP_MAX    = GW'(MIN_IDLE);
  localparam logic [GW-1:0]  GAP_THR    = GW'(MIN_IDLE - 1);

  localparam logic [8:0] SYM_IDLE = 9'h1BC;
  localparam logic [8:0] SYM_SOF  = 9'h1FB;
  localparam logic [8:0] SYM_EOF  = 9'h1FD;
  localparam logic [8:0] SYM_PAD  = 9'h1F7;

  typedef enum logic [2:0] {
    ST_ALIGN,
    ST_IDLE,
    ST_SOF,
    ST_DATA,
    ST_EOF,
    ST_TAIL
  } state_t;

  state_t          state_q, state_d;
  logic [8:0]      sym_q, sym_d;
  logic [ACW-1:0]  align_q, align_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic            und_d;

  logic [8:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [LW-1:0]   level_q;
  logic [8:0]      head;
  logic            push, pop;

  assign s_ready    = (level_q != FULL_LEVEL);
  assign push       = s_valid & s_ready;
  assign head       = mem[rd_ptr];
  assign fifo_level = level_q;
  assign sym_out    = sym_q;
  assign aligning   = (state_q == ST_ALIGN);
  assign busy       = (state_q == ST_SOF) || (state_q == ST_DATA) ||
                      (state_q == ST_EOF) || (state_q == ST_TAIL);

  // Storage carries no reset; occupancy and pointers define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {s_last, s_data};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      level_q <= level_q + 1'b1;
      else if (pop && !push) level_q <= level_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_ALIGN;
      sym_q    <= SYM_IDLE;
      align_q  <= '0;
      gap_q    <= '0;
      underrun <= 1'b0;
    end else begin
      state_q  <= state_d;
      sym_q    <= sym_d;
      align_q  <= align_d;
      gap_q    <= gap_d;
      underrun <= und_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sym_d   = sym_q;
    align_d = align_q;
    gap_d   = gap_q;
    und_d   = 1'b0;
    pop     = 1'b0;
    if (sym_req) begin
      case (state_q)
        ST_ALIGN: begin
          sym_d = SYM_IDLE;
          if (align_q == ALIGN_LAST) begin
            state_d = ST_IDLE;
            gap_d   = GAP_MAX;
          end else begin
            align_d = align_q + 1'b1;
          end
        end
        ST_IDLE: begin
          if ((gap_q >= GAP_THR) && (level_q != '0)) begin
            sym_d   = SYM_SOF;
            state_d = ST_SOF;
          end else begin
            sym_d = SYM_IDLE;
            if (gap_q != GAP_MAX) gap_d = gap_q + 1'b1;
          end
        end
        ST_SOF, ST_DATA: begin
          // Pop is judged on the pre-push occupancy, so a byte never falls through.
          if (level_q != '0) begin
            pop     = 1'b1;
            sym_d   = {1'b0, head[7:0]};
            state_d = head[8] ? ST_EOF : ST_DATA;
          end else begin
            sym_d   = SYM_PAD;
            und_d   = 1'b1;
            state_d = ST_DATA;
          end
        end
        ST_EOF: begin
          sym_d   = SYM_EOF;
          state_d = ST_TAIL;
        end
        ST_TAIL: begin
          sym_d   = SYM_IDLE;
          gap_d   = '0;
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_ALIGN;
          sym_d   = SYM_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serdes_tx_scheduler.sv
// tb/tb_serdes_tx_scheduler.sv - self-checking bench for serdes_tx_scheduler
// Captured symbols are scoreboarded against a queue of expected loads.
module tb_serdes_tx_scheduler;

  logic       clk;
  logic       reset;
  logic       s_valid;
  logic [7:0] s_data;
  logic       s_last;
  logic       s_ready;
  logic       sym_req;
  logic [8:0] sym_out;
  logic       aligning;
  logic       busy;
  logic       underrun;
  logic [4:0] fifo_level;

  serdes_tx_scheduler #(.FIFO_DEPTH(16), .ALIGN_COUNT(8), .MIN_IDLE(2)) dut (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
    .s_ready(s_ready), .sym_req(sym_req), .sym_out(sym_out), .aligning(aligning),
    .busy(busy), .underrun(underrun), .fifo_level(fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  int und_cnt = 0;
  logic [8:0] exp_q [$];
  logic [8:0] exp_sym;

  typedef struct packed {
    logic [3:0]      n;
    logic [3:0][7:0] d;
    logic [7:0][8:0] e;
  } vec_t;
  vec_t tbl [3];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Serdes captures sym_out on the strobe edge; sample it just before that edge.
  always @(negedge clk) begin
    if (underrun === 1'b1) und_cnt++;
    if (sym_req === 1'b1 && reset === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("extra_load", 1, 0);
      end else begin
        exp_sym = exp_q.pop_front();
        check("sym_loaded", sym_out, exp_sym);
      end
    end
  end

  task automatic load();
    sym_req = 1'b1;
    @(posedge clk); #1;
    sym_req = 1'b0;
    repeat (9) @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] d, input logic l);
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    @(posedge clk); #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic expect_n(input logic [8:0] s, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(s);
  endtask

  initial begin
    // Element 0 is rightmost in each packed field.
    tbl[0].n = 4'd3;
    tbl[0].d = {8'h00, 8'h21, 8'h69, 8'h4F};
    tbl[0].e = {9'h000, 9'h1BC, 9'h1FD, 9'h021, 9'h069, 9'h04F, 9'h1FB, 9'h1BC};
    tbl[1].n = 4'd1;
    tbl[1].d = {24'h0, 8'hA5};
    tbl[1].e = {27'h0, 9'h1BC, 9'h1FD, 9'h0A5, 9'h1FB, 9'h1BC};
    tbl[2].n = 4'd4;
    tbl[2].d = {8'hFB, 8'hBC, 8'hFF, 8'h00};
    tbl[2].e = {9'h1BC, 9'h1FD, 9'h0FB, 9'h0BC, 9'h0FF, 9'h000, 9'h1FB, 9'h1BC};

    reset = 1'b0; s_valid = 1'b0; s_data = 8'h0; s_last = 1'b0; sym_req = 1'b0;
    @(posedge clk); #1;
    s_valid = 1'b1; s_data = 8'h77; sym_req = 1'b1;
    repeat (3) @(posedge clk); #1;
    s_valid = 1'b0; sym_req = 1'b0;
    check("rst_sym", sym_out, 9'h1BC);
    check("rst_aligning", aligning, 1);
    check("rst_busy", busy, 0);
    check("rst_underrun", underrun, 0);
    check("rst_level", fifo_level, 0);
    check("rst_ready", s_ready, 1);
    reset = 1'b1;
    @(posedge clk); #1;

    // Alignment burst
    expect_n(9'h1BC, 9);
    for (int i = 0; i < 7; i++) load();
    check("align_still", aligning, 1);
    load();
    check("align_done", aligning, 0);
    load();
    check("idle_sym", sym_out, 9'h1BC);
    check("align_drain", exp_q.size(), 0);

    // Table of single frames
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < int'(tbl[r].n); i++)
        push_byte(tbl[r].d[i], i == int'(tbl[r].n) - 1);
      check("tbl_level", fifo_level, tbl[r].n);
      for (int k = 0; k < int'(tbl[r].n) + 4; k++) exp_q.push_back(tbl[r].e[k]);
      for (int k = 1; k <= int'(tbl[r].n) + 4; k++) begin
        load();
        check("tbl_busy", busy, k <= int'(tbl[r].n) + 2);
      end
      check("tbl_drain", exp_q.size(), 0);
      check("tbl_level_end", fifo_level, 0);
    end

    // Mid-frame underrun
    und_cnt = 0;
    push_byte(8'h4F, 1'b0);
    exp_q.push_back(9'h1BC); exp_q.push_back(9'h1FB); exp_q.push_back(9'h04F);
    expect_n(9'h1F7, 3);
    exp_q.push_back(9'h069); exp_q.push_back(9'h1FD); exp_q.push_back(9'h1BC);
    for (int i = 0; i < 5; i++) load();
    check("pad_sym", sym_out, 9'h1F7);
    push_byte(8'h69, 1'b1);
    for (int i = 0; i < 4; i++) load();
    check("und_pulses", und_cnt, 3);
    check("und_drain", exp_q.size(), 0);

    // Back-to-back frames honour the idle gap
    push_byte(8'h01, 1'b1);
    push_byte(8'h02, 1'b1);
    exp_q.push_back(9'h1BC); exp_q.push_back(9'h1FB); exp_q.push_back(9'h001);
    exp_q.push_back(9'h1FD); exp_q.push_back(9'h1BC); exp_q.push_back(9'h1BC);
    exp_q.push_back(9'h1FB); exp_q.push_back(9'h002); exp_q.push_back(9'h1FD);
    exp_q.push_back(9'h1BC);
    for (int i = 0; i < 10; i++) load();
    check("gap_drain", exp_q.size(), 0);

    // Fill past full with no strobes
    for (int i = 0; i < 20; i++) push_byte(8'h10 + 8'(i), i == 15);
    check("full_ready", s_ready, 0);
    check("full_level", fifo_level, 16);
    exp_q.push_back(9'h1BC); exp_q.push_back(9'h1FB);
    for (int i = 0; i < 16; i++) exp_q.push_back({1'b0, 8'h10 + 8'(i)});
    exp_q.push_back(9'h1FD); exp_q.push_back(9'h1BC);
    load(); load();
    check("full_ready_again", s_ready, 1);
    for (int i = 0; i < 18; i++) load();
    check("full_drain", exp_q.size(), 0);
    check("full_level_end", fifo_level, 0);

    // Reset during DATA
    push_byte(8'hA1, 1'b0); push_byte(8'hA2, 1'b0); push_byte(8'hA3, 1'b1);
    exp_q.push_back(9'h1BC); exp_q.push_back(9'h1FB); exp_q.push_back(9'h0A1);
    for (int i = 0; i < 3; i++) load();
    check("pre_rst_sym", sym_out, 9'h0A2);
    check("pre_rst_busy", busy, 1);
    #3 reset = 1'b0;
    #1;
    check("mid_rst_sym", sym_out, 9'h1BC);
    check("mid_rst_level", fifo_level, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_aligning", aligning, 1);
    repeat (3) @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    push_byte(8'h5A, 1'b1);
    expect_n(9'h1BC, 9);
    exp_q.push_back(9'h1FB); exp_q.push_back(9'h05A); exp_q.push_back(9'h1FD);
    exp_q.push_back(9'h1BC);
    for (int i = 0; i < 8; i++) load();
    check("realign_hold", busy, 0);
    for (int i = 0; i < 5; i++) load();
    check("realign_drain", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
